dec_in_frame_packer: RTL and testbench



---
 rtl/dec_in_frame_packer_pkg.sv | 22 ++
 rtl/dec_in_frame_packer.sv | 92 +++++++++
 tb/tb_dec_in_frame_packer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dec_in_frame_packer_pkg.sv
// Shared wavelet front-end definitions: frame geometry, lane slicing and
// ADC code conversion used by the input gearbox and future ADC front-ends.
package dec_in_frame_packer_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int L1_LANES       = 16;

    function automatic int calc_ratio(input int out_lanes, input int in_lanes);
        return out_lanes / in_lanes;
    endfunction

    function automatic int lane_base(input int k, input int w);
        return k * w;
    endfunction

    // Offset-binary to two's complement is a flip of the sample MSB; samples
    // travel zero-extended to 64 bits so one function serves every width.
    function automatic logic [63:0] offset_to_twos(input logic [63:0] s, input int w);
        return s ^ (64'd1 << (w - 1));
    endfunction

endpackage

// File: rtl/dec_in_frame_packer.sv
// Input gearbox: packs IN_LANES-wide ADC beats into OUT_LANES-wide frames for
// the first decomposition level, with sync-driven realignment and counters.
module dec_in_frame_packer
    import dec_in_frame_packer_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int IN_LANES      = 4,
    parameter int OUT_LANES     = L1_LANES,
    parameter bit OFFSET_BINARY = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic                           in_sync,
    input  logic [IN_LANES*DATA_WIDTH-1:0] in_data,
    output logic                           din_valid,
    output logic [OUT_LANES*DATA_WIDTH-1:0] din_frame,
    output logic [31:0]                    frame_cnt,
    output logic [15:0]                    discard_cnt
);

    localparam int RATIO = calc_ratio(OUT_LANES, IN_LANES);
    localparam int PH_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int FW    = OUT_LANES * DATA_WIDTH;
    localparam logic [PH_W-1:0] LAST = PH_W'(RATIO - 1);

    function automatic logic [DATA_WIDTH-1:0] capture(input logic [DATA_WIDTH-1:0] s);
        logic [63:0] w;
        w = 64'(s);
        if (OFFSET_BINARY) w = offset_to_twos(w, DATA_WIDTH);
        return w[DATA_WIDTH-1:0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic [PH_W-1:0] phase_p0;
    logic [FW-1:0]   stage_p0;
    logic [FW-1:0]   frame_p1;
    logic            vld_p1;
    logic [31:0]     frame_cnt_p1;
    logic [15:0]     discard_cnt_p1;

    logic [PH_W-1:0] wr_phase;
    logic [PH_W-1:0] phase_nxt;
    logic [FW-1:0]   stage_nxt;
    logic            emit;

    // p0: capture the beat into staging; a sync realigns it to slot group 0
    always_comb begin
        wr_phase  = in_sync ? '0 : phase_p0;
        stage_nxt = stage_p0;
        if (in_valid) begin
            for (int j = 0; j < IN_LANES; j++) begin
                stage_nxt[lane_base(int'(wr_phase) * IN_LANES + j, DATA_WIDTH) +: DATA_WIDTH] =
                    capture(in_data[lane_base(j, DATA_WIDTH) +: DATA_WIDTH]);
            end
        end
        emit = in_valid && (wr_phase == LAST);
        if (in_valid)     phase_nxt = emit ? '0 : wr_phase + 1'b1;
        else if (in_sync) phase_nxt = '0;
        else              phase_nxt = phase_p0;
    end

    // p1: frame, pulse and counters are all registered
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_p0       <= '0;
            stage_p0       <= '0;
            frame_p1       <= '0;
            vld_p1         <= 1'b0;
            frame_cnt_p1   <= '0;
            discard_cnt_p1 <= '0;
        end else begin
            phase_p0 <= phase_nxt;
            stage_p0 <= stage_nxt;
            vld_p1   <= emit;
            if (emit) begin
                frame_p1     <= stage_nxt;
                frame_cnt_p1 <= frame_cnt_p1 + 32'd1;
            end
            if (in_sync && (phase_p0 != '0)) discard_cnt_p1 <= sat_inc16(discard_cnt_p1);
        end
    end

    assign din_valid   = vld_p1;
    assign din_frame   = frame_p1;
    assign frame_cnt   = frame_cnt_p1;
    assign discard_cnt = discard_cnt_p1;

endmodule

// File: tb/tb_dec_in_frame_packer.sv
// Directed bench for the input gearbox: vector table plus hand-written
// sequences for contiguous streaming, gaps, mid-frame reset and offset binary.
module tb_dec_in_frame_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_sync = 1'b0;
    logic [63:0]  in_data = '0;

    logic         din_valid, ob_valid;
    logic [255:0] din_frame, ob_frame;
    logic [31:0]  frame_cnt, ob_fcnt;
    logic [15:0]  discard_cnt, ob_dcnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dec_in_frame_packer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync), .in_data(in_data),
        .din_valid(din_valid), .din_frame(din_frame), .frame_cnt(frame_cnt), .discard_cnt(discard_cnt)
    );

    dec_in_frame_packer #(.OFFSET_BINARY(1'b1)) dut_ob (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync), .in_data(in_data),
        .din_valid(ob_valid), .din_frame(ob_frame), .frame_cnt(ob_fcnt), .discard_cnt(ob_dcnt)
    );

    typedef struct {
        logic         v;
        logic         s;
        logic [63:0]  d;
        logic         ev;
        logic [31:0]  efc;
        logic [15:0]  edc;
        logic [255:0] efr;
    } vec_t;

    vec_t tbl[32];
    int   n = 0;

    task automatic add(input logic v, input logic s, input logic [63:0] d, input logic ev,
                       input logic [31:0] efc, input logic [15:0] edc, input logic [255:0] efr);
        tbl[n] = '{v, s, d, ev, efc, edc, efr};
        n++;
    endtask

    function automatic logic [63:0] rep4(input logic [15:0] x);
        return {4{x}};
    endfunction

    function automatic logic [63:0] beat(input int b);
        return {16'(4 * b + 3), 16'(4 * b + 2), 16'(4 * b + 1), 16'(4 * b)};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [63:0] d);
        in_valid = v;
        in_sync  = s;
        in_data  = d;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [255:0] fr;
        logic [255:0] prev;
        int pulses;

        // Vector table: expected outputs seen one edge after each row is driven
        fr = '0;
        add(1, 0, beat(0), 0, 0, 0, fr);
        add(1, 0, beat(1), 0, 0, 0, fr);
        add(1, 0, beat(2), 0, 0, 0, fr);
        fr = {beat(3), beat(2), beat(1), beat(0)};
        add(1, 0, beat(3), 1, 1, 0, fr);
        add(0, 0, '0, 0, 1, 0, fr);
        add(1, 0, rep4(16'h2222), 0, 1, 0, fr);
        add(1, 0, rep4(16'h2222), 0, 1, 0, fr);
        add(1, 1, rep4(16'h1111), 0, 1, 1, fr);
        add(1, 0, rep4(16'h3333), 0, 1, 1, fr);
        add(1, 0, rep4(16'h4444), 0, 1, 1, fr);
        fr = {rep4(16'h5555), rep4(16'h4444), rep4(16'h3333), rep4(16'h1111)};
        add(1, 0, rep4(16'h5555), 1, 2, 1, fr);
        add(0, 0, '0, 0, 2, 1, fr);
        add(0, 1, '0, 0, 2, 1, fr);
        add(1, 0, rep4(16'h6666), 0, 2, 1, fr);
        add(0, 1, '0, 0, 2, 2, fr);
        add(1, 0, rep4(16'h7777), 0, 2, 2, fr);
        add(1, 0, rep4(16'h7777), 0, 2, 2, fr);
        add(1, 0, rep4(16'h7777), 0, 2, 2, fr);
        fr = {16{16'h7777}};
        add(1, 0, rep4(16'h7777), 1, 3, 2, fr);
        add(1, 1, rep4(16'h8888), 0, 3, 2, fr);
        add(1, 0, rep4(16'h8888), 0, 3, 2, fr);
        add(1, 0, rep4(16'h8888), 0, 3, 2, fr);
        fr = {16{16'h8888}};
        add(1, 0, rep4(16'h8888), 1, 4, 2, fr);

        step();
        do_reset();
        chk("reset_valid", 256'(din_valid), 256'(0));
        chk("reset_frame", din_frame, '0);
        chk("reset_fcnt", 256'(frame_cnt), 256'(0));
        chk("reset_dcnt", 256'(discard_cnt), 256'(0));

        for (int i = 0; i < n; i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].d);
            step();
            chk($sformatf("tbl%0d_valid", i), 256'(din_valid), 256'(tbl[i].ev));
            chk($sformatf("tbl%0d_fcnt", i), 256'(frame_cnt), 256'(tbl[i].efc));
            chk($sformatf("tbl%0d_dcnt", i), 256'(discard_cnt), 256'(tbl[i].edc));
            chk($sformatf("tbl%0d_frame", i), din_frame, tbl[i].efr);
        end

        // 40 contiguous beats: a pulse every fourth cycle, no bubbles
        do_reset();
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b0, beat(i));
            step();
            chk($sformatf("stream%0d_valid", i), 256'(din_valid), 256'((i % 4) == 3));
            if (din_valid) pulses++;
        end
        drive(1'b0, 1'b0, '0);
        step();
        chk("stream_pulses", 256'(pulses), 256'(10));
        chk("stream_fcnt", 256'(frame_cnt), 256'(10));
        chk("stream_dcnt", 256'(discard_cnt), 256'(0));
        chk("stream_frame", din_frame, {beat(39), beat(38), beat(37), beat(36)});
        chk("stream_after_valid", 256'(din_valid), 256'(0));

        // Beats separated by gaps of 0, 3 and 7 idle cycles
        do_reset();
        prev = din_frame;
        for (int b = 0; b < 4; b++) begin
            int gap;
            gap = (b == 1) ? 0 : (b == 2) ? 3 : (b == 3) ? 7 : 0;
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF);
                step();
                chk($sformatf("gap%0d_%0d_valid", b, g), 256'(din_valid), 256'(0));
                chk($sformatf("gap%0d_%0d_frame", b, g), din_frame, prev);
            end
            drive(1'b1, 1'b0, beat(b + 64));
            step();
            chk($sformatf("gapbeat%0d_valid", b), 256'(din_valid), 256'(b == 3));
        end
        chk("gap_frame", din_frame, {beat(67), beat(66), beat(65), beat(64)});
        chk("gap_fcnt", 256'(frame_cnt), 256'(1));
        drive(1'b0, 1'b0, '0);
        step();
        chk("gap_pulse_width", 256'(din_valid), 256'(0));

        // Reset mid-frame loses the partial frame without counting it
        do_reset();
        for (int b = 0; b < 3; b++) begin
            drive(1'b1, 1'b0, rep4(16'h1234));
            step();
        end
        do_reset();
        chk("midrst_fcnt", 256'(frame_cnt), 256'(0));
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, 1'b0, rep4(16'hABCD));
            step();
            chk($sformatf("midrst_beat%0d_valid", b), 256'(din_valid), 256'(b == 3));
        end
        chk("midrst_frame", din_frame, {16{16'hABCD}});
        chk("midrst_fcnt1", 256'(frame_cnt), 256'(1));
        chk("midrst_dcnt", 256'(discard_cnt), 256'(0));

        // Offset-binary instance flips every sample MSB at capture
        do_reset();
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, 1'b0, (b < 2) ? rep4(16'h8000) : rep4(16'h0000));
            step();
        end
        chk("ob_valid", 256'(ob_valid), 256'(1));
        chk("ob_frame", ob_frame, {{8{16'h8000}}, {8{16'h0000}}});
        chk("plain_frame", din_frame, {{8{16'h0000}}, {8{16'h8000}}});
        chk("ob_fcnt", 256'(ob_fcnt), 256'(1));
        chk("ob_dcnt", 256'(ob_dcnt), 256'(0));

        drive(1'b0, 1'b0, '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
